// File: rtl/cu_pkg.sv
// Shared types and constants for the parametrised multi-cycle control unit.
// Field offsets are derived from the widths so every file slices the same way.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_JMP,
        CL_BZ,
        CL_HALT,
        CL_ILL
    } iclass_t;

    localparam int OP_NOP    = 0;
    localparam int OP_ALU_LO = 1;
    localparam int OP_ALU_HI = 7;
    localparam int OP_LOAD   = 8;
    localparam int OP_STORE  = 9;
    localparam int OP_JMP    = 10;
    localparam int OP_BZ     = 11;
    localparam int OP_HALT   = 15;

    function automatic int op_lsb(int bus_width, int opcode_len);
        return bus_width - opcode_len;
    endfunction

    function automatic int a_lsb(int addr_bw, int destw);
        return addr_bw + destw;
    endfunction

    function automatic int b_lsb(int destw);
        return destw;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction splitter: fields, instruction class and
// illegal-opcode flag for one instruction word.
module cu_decode
    import cu_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int OPCODE_LEN = 4,
    parameter int ADDR_AW    = 4,
    parameter int ADDR_BW    = 4,
    parameter int DESTW      = 4,
    localparam int PC_W      = BUS_WIDTH - OPCODE_LEN
) (
    input  logic [BUS_WIDTH-1:0] word,
    output logic [ADDR_AW-1:0]   fld_a,
    output logic [ADDR_BW-1:0]   fld_b,
    output logic [DESTW-1:0]     fld_dest,
    output logic [PC_W-1:0]      fld_tgt,
    output logic [2:0]           fld_alu_op,
    output iclass_t              iclass,
    output logic                 illegal
);

    localparam int OP_LSB = op_lsb(BUS_WIDTH, OPCODE_LEN);
    localparam int A_LSB  = a_lsb(ADDR_BW, DESTW);
    localparam int B_LSB  = b_lsb(DESTW);

    logic [OPCODE_LEN-1:0] opcode;

    assign opcode     = word[OP_LSB +: OPCODE_LEN];
    assign fld_a      = word[A_LSB +: ADDR_AW];
    assign fld_b      = word[B_LSB +: ADDR_BW];
    assign fld_dest   = word[0 +: DESTW];
    assign fld_tgt    = word[PC_W-1:0];
    assign fld_alu_op = opcode[2:0];
    assign illegal    = (iclass == CL_ILL);

    // Wide opcodes compare zero-extended, so upper bits must be clear.
    always_comb begin
        iclass = CL_ILL;
        unique case (1'b1)
            (opcode == OPCODE_LEN'(OP_NOP)):   iclass = CL_NOP;
            (opcode >= OPCODE_LEN'(OP_ALU_LO) &&
             opcode <= OPCODE_LEN'(OP_ALU_HI)): iclass = CL_ALU;
            (opcode == OPCODE_LEN'(OP_LOAD)):  iclass = CL_LOAD;
            (opcode == OPCODE_LEN'(OP_STORE)): iclass = CL_STORE;
            (opcode == OPCODE_LEN'(OP_JMP)):   iclass = CL_JMP;
            (opcode == OPCODE_LEN'(OP_BZ)):    iclass = CL_BZ;
            (opcode == OPCODE_LEN'(OP_HALT)):  iclass = CL_HALT;
            default:                           iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/cu_fsm_param.sv
// Multi-cycle control unit: FETCH-DECODE-EXEC-WB sequencer. Every output is
// a flop loaded with the value belonging to the state being entered.
module cu_fsm_param
    import cu_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int OPCODE_LEN = 4,
    parameter int ADDR_AW    = 4,
    parameter int ADDR_BW    = 4,
    parameter int DESTW      = 4,
    localparam int PC_W      = BUS_WIDTH - OPCODE_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] instr_rdata,
    output logic                 instr_req,
    input  logic                 instr_ack,
    input  logic                 zero_flag,
    input  logic                 dmem_ack,
    output logic [ADDR_AW-1:0]   addr_A,
    output logic [ADDR_BW-1:0]   addr_B,
    output logic [DESTW-1:0]     addr_dest,
    output logic                 en_decA,
    output logic                 en_decB,
    output logic                 en_dest,
    output logic                 rf_we,
    output logic [2:0]           alu_op,
    output logic                 alu_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_target,
    output logic                 halted,
    output logic                 illegal_op
);

    state_t               state, state_n;
    logic [BUS_WIDTH-1:0] ir, ir_n, dec_word;

    logic [ADDR_AW-1:0] d_a;
    logic [ADDR_BW-1:0] d_b;
    logic [DESTW-1:0]   d_dest;
    logic [PC_W-1:0]    d_tgt;
    logic [2:0]         d_alu_op;
    iclass_t            d_cls;
    logic               d_ill;

    logic [ADDR_AW-1:0] addr_A_n;
    logic [ADDR_BW-1:0] addr_B_n;
    logic [DESTW-1:0]   addr_dest_n;
    logic [2:0]         alu_op_n;
    logic [PC_W-1:0]    pc_target_n;
    logic instr_req_n, en_decA_n, en_decB_n, en_dest_n, rf_we_n;
    logic alu_en_n, dmem_req_n, dmem_we_n, pc_inc_n, pc_load_n;
    logic halted_n, illegal_op_n;

    // While fetching, decode the incoming word so fields load on the ack edge.
    assign dec_word = (state == FETCH) ? instr_rdata : ir;

    cu_decode #(
        .BUS_WIDTH (BUS_WIDTH),
        .OPCODE_LEN(OPCODE_LEN),
        .ADDR_AW   (ADDR_AW),
        .ADDR_BW   (ADDR_BW),
        .DESTW     (DESTW)
    ) u_dec (
        .word      (dec_word),
        .fld_a     (d_a),
        .fld_b     (d_b),
        .fld_dest  (d_dest),
        .fld_tgt   (d_tgt),
        .fld_alu_op(d_alu_op),
        .iclass    (d_cls),
        .illegal   (d_ill)
    );

    always_comb begin
        state_n      = state;
        ir_n         = ir;
        addr_A_n     = addr_A;
        addr_B_n     = addr_B;
        addr_dest_n  = addr_dest;
        alu_op_n     = alu_op;
        pc_target_n  = pc_target;
        halted_n     = halted;
        instr_req_n  = 1'b0;
        en_decA_n    = 1'b0;
        en_decB_n    = 1'b0;
        en_dest_n    = 1'b0;
        rf_we_n      = 1'b0;
        alu_en_n     = 1'b0;
        dmem_req_n   = 1'b0;
        dmem_we_n    = 1'b0;
        pc_inc_n     = 1'b0;
        pc_load_n    = 1'b0;
        illegal_op_n = 1'b0;
        unique case (state)
            FETCH: begin
                if (instr_req && instr_ack) begin
                    state_n     = DECODE;
                    ir_n        = instr_rdata;
                    addr_A_n    = d_a;
                    addr_B_n    = d_b;
                    addr_dest_n = d_dest;
                    pc_target_n = d_tgt;
                    alu_op_n    = (d_cls == CL_ALU) ? d_alu_op : 3'd0;
                    en_decA_n   = d_cls inside {CL_ALU, CL_LOAD, CL_STORE};
                    en_decB_n   = d_cls inside {CL_ALU, CL_LOAD, CL_STORE};
                end else begin
                    instr_req_n = 1'b1;
                end
            end
            DECODE: begin
                state_n = EXEC;
                unique case (d_cls)
                    CL_ALU:  alu_en_n = 1'b1;
                    CL_LOAD: dmem_req_n = 1'b1;
                    CL_STORE: begin
                        dmem_req_n = 1'b1;
                        dmem_we_n  = 1'b1;
                        pc_inc_n   = 1'b1;
                    end
                    CL_JMP:  pc_load_n = 1'b1;
                    CL_BZ: begin
                        pc_load_n = zero_flag;
                        pc_inc_n  = !zero_flag;
                    end
                    CL_HALT: pc_inc_n = 1'b0;
                    default: begin
                        pc_inc_n     = 1'b1;
                        illegal_op_n = d_ill;
                    end
                endcase
            end
            EXEC: begin
                unique case (d_cls)
                    CL_ALU: begin
                        state_n   = WB;
                        en_dest_n = 1'b1;
                        rf_we_n   = 1'b1;
                        pc_inc_n  = 1'b1;
                    end
                    CL_LOAD: begin
                        if (dmem_req && dmem_ack) begin
                            state_n   = WB;
                            en_dest_n = 1'b1;
                            rf_we_n   = 1'b1;
                            pc_inc_n  = 1'b1;
                        end else begin
                            dmem_req_n = 1'b1;
                        end
                    end
                    CL_STORE: begin
                        if (dmem_req && dmem_ack) begin
                            state_n     = FETCH;
                            instr_req_n = 1'b1;
                        end else begin
                            dmem_req_n = 1'b1;
                            dmem_we_n  = 1'b1;
                        end
                    end
                    CL_HALT: begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end
                    default: begin
                        state_n     = FETCH;
                        instr_req_n = 1'b1;
                    end
                endcase
            end
            WB: begin
                state_n     = FETCH;
                instr_req_n = 1'b1;
            end
            HALT:    halted_n = 1'b1;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            ir         <= '0;
            addr_A     <= '0;
            addr_B     <= '0;
            addr_dest  <= '0;
            alu_op     <= '0;
            pc_target  <= '0;
            halted     <= 1'b0;
            instr_req  <= 1'b0;
            en_decA    <= 1'b0;
            en_decB    <= 1'b0;
            en_dest    <= 1'b0;
            rf_we      <= 1'b0;
            alu_en     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_n;
            ir         <= ir_n;
            addr_A     <= addr_A_n;
            addr_B     <= addr_B_n;
            addr_dest  <= addr_dest_n;
            alu_op     <= alu_op_n;
            pc_target  <= pc_target_n;
            halted     <= halted_n;
            instr_req  <= instr_req_n;
            en_decA    <= en_decA_n;
            en_decB    <= en_decB_n;
            en_dest    <= en_dest_n;
            rf_we      <= rf_we_n;
            alu_en     <= alu_en_n;
            dmem_req   <= dmem_req_n;
            dmem_we    <= dmem_we_n;
            pc_inc     <= pc_inc_n;
            pc_load    <= pc_load_n;
            illegal_op <= illegal_op_n;
        end
    end

endmodule

// File: tb/tb_cu_fsm_param.sv
// Bench for cu_fsm_param: builds a per-cycle script of expected outputs and
// stimulus from the opcode rules, then replays it against the DUT.
module tb_cu_fsm_param;

    localparam int K_NOP   = 0;
    localparam int K_ALU   = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_JMP   = 4;
    localparam int K_BZ    = 5;
    localparam int K_HALT  = 6;
    localparam int K_ILL   = 7;

    typedef struct packed {
        logic        instr_req;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  d;
        logic        en_a;
        logic        en_b;
        logic        en_d;
        logic        rf_we;
        logic [2:0]  alu_op;
        logic        alu_en;
        logic        dmem_req;
        logic        dmem_we;
        logic        pc_inc;
        logic        pc_load;
        logic [11:0] tgt;
        logic        halted;
        logic        ill;
    } out_t;

    typedef struct packed {
        logic        reset;
        logic        iack;
        logic        dack;
        logic        zf;
        logic [15:0] rdata;
    } in_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr_rdata = '0;
    logic        instr_ack = 1'b0;
    logic        zero_flag = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        instr_req;
    logic [3:0]  addr_A, addr_B, addr_dest;
    logic        en_decA, en_decB, en_dest, rf_we;
    logic [2:0]  alu_op;
    logic        alu_en, dmem_req, dmem_we, pc_inc, pc_load;
    logic [11:0] pc_target;
    logic        halted, illegal_op;

    always #5 clk = ~clk;

    cu_fsm_param dut (
        .clk        (clk),
        .reset      (reset),
        .instr_rdata(instr_rdata),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .zero_flag  (zero_flag),
        .dmem_ack   (dmem_ack),
        .addr_A     (addr_A),
        .addr_B     (addr_B),
        .addr_dest  (addr_dest),
        .en_decA    (en_decA),
        .en_decB    (en_decB),
        .en_dest    (en_dest),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    out_t act;
    assign act = {instr_req, addr_A, addr_B, addr_dest, en_decA, en_decB,
                  en_dest, rf_we, alu_op, alu_en, dmem_req, dmem_we,
                  pc_inc, pc_load, pc_target, halted, illegal_op};

    out_t exp_q[$];
    in_t  stim_q[$];
    bit   chk_q[$];
    out_t held;
    bit   halted_m;
    int   n_assert = 0;
    int   n_fail = 0;
    int   f_at, dec_at, ex_at, wb_at, dreq_n;

    function automatic int cls_of(logic [3:0] op);
        if (op == 4'h0) return K_NOP;
        if (op >= 4'h1 && op <= 4'h7) return K_ALU;
        if (op == 4'h8) return K_LOAD;
        if (op == 4'h9) return K_STORE;
        if (op == 4'hA) return K_JMP;
        if (op == 4'hB) return K_BZ;
        if (op == 4'hF) return K_HALT;
        return K_ILL;
    endfunction

    function automatic out_t base();
        out_t o;
        o = held;
        o.halted = halted_m;
        return o;
    endfunction

    // Acks outside their request window are randomised to prove they are ignored.
    function automatic in_t idle_in(out_t o, logic z);
        in_t s;
        s.reset = 1'b0;
        s.iack  = o.instr_req ? 1'b0 : 1'($urandom_range(0, 1));
        s.dack  = o.dmem_req ? 1'b0 : 1'($urandom_range(0, 1));
        s.zf    = z;
        s.rdata = 16'($urandom);
        return s;
    endfunction

    function automatic void push(out_t o, in_t s, bit c);
        exp_q.push_back(o);
        stim_q.push_back(s);
        chk_q.push_back(c);
    endfunction

    function automatic out_t at(int i);
        return exp_q[i];
    endfunction

    function automatic void add_reset();
        in_t  s;
        out_t o;
        s = stim_q[stim_q.size()-1];
        s.reset = 1'b1;
        s.iack  = 1'b1;
        s.dack  = 1'b1;
        stim_q[stim_q.size()-1] = s;
        held = '0;
        halted_m = 1'b0;
        o = '0;
        s = idle_in(o, 1'b0);
        s.iack = 1'b1;
        push(o, s, 1'b1);
    endfunction

    function automatic void add_halt(int n);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o = base();
            push(o, idle_in(o, 1'b0), 1'b1);
        end
    endfunction

    function automatic void add_instr(logic [15:0] w, logic z, int df, int dd,
                                      int abort_at);
        int   k;
        out_t o;
        in_t  s;
        k = cls_of(w[15:12]);
        f_at = exp_q.size();
        for (int i = 0; i <= df; i++) begin
            o = base();
            o.instr_req = 1'b1;
            s = idle_in(o, z);
            if (i == df) begin
                s.iack  = 1'b1;
                s.rdata = w;
            end
            push(o, s, 1'b1);
        end
        held.a      = w[11:8];
        held.b      = w[7:4];
        held.d      = w[3:0];
        held.tgt    = w[11:0];
        held.alu_op = (k == K_ALU) ? w[14:12] : 3'd0;
        dec_at = exp_q.size();
        o = base();
        o.en_a = (k == K_ALU || k == K_LOAD || k == K_STORE);
        o.en_b = o.en_a;
        push(o, idle_in(o, z), 1'b1);
        ex_at  = exp_q.size();
        wb_at  = -1;
        dreq_n = 0;
        o = base();
        case (k)
            K_ALU:   o.alu_en = 1'b1;
            K_JMP:   o.pc_load = 1'b1;
            K_BZ: begin
                o.pc_load = z;
                o.pc_inc  = !z;
            end
            K_NOP:   o.pc_inc = 1'b1;
            K_ILL: begin
                o.pc_inc = 1'b1;
                o.ill    = 1'b1;
            end
            default: o.pc_inc = 1'b0;
        endcase
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= dd; i++) begin
                o = base();
                o.dmem_req = 1'b1;
                o.dmem_we  = (k == K_STORE);
                o.pc_inc   = (k == K_STORE && i == 0);
                s = idle_in(o, z);
                s.dack = (i == dd && abort_at < 0);
                push(o, s, 1'b1);
                dreq_n++;
                if (abort_at >= 0 && i == abort_at) begin
                    add_reset();
                    return;
                end
            end
        end else begin
            push(o, idle_in(o, z), 1'b1);
        end
        if (k == K_HALT) halted_m = 1'b1;
        if (k == K_ALU || k == K_LOAD) begin
            wb_at = exp_q.size();
            o = base();
            o.en_d   = 1'b1;
            o.rf_we  = 1'b1;
            o.pc_inc = 1'b1;
            push(o, idle_in(o, z), 1'b1);
        end
    endfunction

    function automatic void pin(string nm, int got, int want);
        n_assert++;
        if (got != want) begin
            n_fail++;
            $display("FAIL pin_%s got %0d want %0d", nm, got, want);
        end
    endfunction

    initial begin
        out_t o;
        in_t  s;
        int   p_f;
        o = '0;
        s = '0;
        s.reset = 1'b1;
        held = '0;
        halted_m = 1'b0;
        push(o, s, 1'b0);
        push(o, s, 1'b1);
        add_reset();

        add_instr(16'h1234, 1'b0, 0, 0, -1);
        p_f = f_at;
        pin("alu_addr_a", int'(at(dec_at).a), 2);
        pin("alu_addr_b", int'(at(dec_at).b), 3);
        pin("alu_dest", int'(at(dec_at).d), 4);
        pin("alu_op", int'(at(ex_at).alu_op), 1);
        pin("alu_wb", int'(at(wb_at).rf_we & at(wb_at).pc_inc), 1);
        add_instr(16'h0000, 1'b0, 0, 0, -1);
        pin("alu_gap", f_at - p_f, 4);
        p_f = f_at;
        add_instr(16'h8506, 1'b0, 0, 2, -1);
        pin("nop_gap", f_at - p_f, 3);
        pin("load_dreq", dreq_n, 3);
        pin("load_dest", int'(at(wb_at).d), 6);
        add_instr(16'h9120, 1'b0, 1, 1, -1);
        pin("store_we", int'(at(ex_at).dmem_we), 1);
        pin("store_no_wb", wb_at, -1);
        add_instr(16'hB0FF, 1'b1, 0, 0, -1);
        pin("bz_taken", int'(at(ex_at).pc_load), 1);
        pin("bz_tgt", int'(at(ex_at).tgt), 'h0FF);
        add_instr(16'hB0FF, 1'b0, 2, 0, -1);
        pin("bz_not_taken", int'(at(ex_at).pc_inc), 1);
        add_instr(16'hA123, 1'b0, 0, 0, -1);
        pin("jmp_tgt", int'(at(ex_at).tgt), 'h123);
        add_instr(16'hC000, 1'b0, 0, 0, -1);
        pin("ill_pulse", int'(at(ex_at).ill), 1);
        add_instr(16'h8506, 1'b0, 0, 5, 2);

        for (int n = 0; n < 250; n++) begin
            logic [15:0] w;
            w = 16'($urandom);
            add_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
            if (w[15:12] == 4'hF) begin
                add_halt($urandom_range(2, 6));
                add_reset();
            end
        end

        add_instr(16'hF000, 1'b0, 0, 0, -1);
        add_halt(20);
        pin("halt_no_req", int'(at(exp_q.size()-1).instr_req), 0);
        add_reset();
        add_instr(16'h2345, 1'b1, 1, 0, -1);

        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (chk_q[k]) begin
                n_assert++;
                if (act !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL cyc%0d outputs act=%h exp=%h",
                             k, act, exp_q[k]);
                end
                n_assert++;
                if (instr_req && dmem_req) begin
                    n_fail++;
                    $display("FAIL cyc%0d req_overlap act=1 exp=0", k);
                end
                n_assert++;
                if (pc_inc && pc_load) begin
                    n_fail++;
                    $display("FAIL cyc%0d pc_both act=1 exp=0", k);
                end
            end
            s = stim_q[k];
            reset       = s.reset;
            instr_ack   = s.iack;
            dmem_ack    = s.dack;
            zero_flag   = s.zf;
            instr_rdata = s.rdata;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_fsm_param.md
Name: cu_fsm_param

Overview:
Parametrised multi-cycle control unit; successor to the single-opcode decoder CU.
- Fetches an instruction word over a req/ack handshake and splits it into opcode / A / B / dest fields.
- Sequences FETCH-DECODE-EXECUTE-WRITEBACK and drives register-file decoder enables, ALU control, data-memory handshake and PC control.
- Sits between instruction memory, register file, ALU and PC in the processor datapath.

Parameters:
BUS_WIDTH, 16, instruction word width
OPCODE_LEN, 4, opcode field width (MSBs); must be >= 4
ADDR_AW, 4, operand-A register address width
ADDR_BW, 4, operand-B register address width
DESTW, 4, destination register address width
Constraint: OPCODE_LEN+ADDR_AW+ADDR_BW+DESTW == BUS_WIDTH. Local PC_W = BUS_WIDTH-OPCODE_LEN.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
instr_rdata  in  BUS_WIDTH  instruction word, valid when instr_ack=1
instr_req  out  1  instruction fetch request
instr_ack  in  1  fetch complete
zero_flag  in  1  ALU zero flag, used by BZ
dmem_ack  in  1  data access complete
addr_A  out  ADDR_AW  operand-A register index
addr_B  out  ADDR_BW  operand-B register index
addr_dest  out  DESTW  destination register index
en_decA  out  1  read-decoder A enable
en_decB  out  1  read-decoder B enable
en_dest  out  1  write-decoder enable
rf_we  out  1  register-file write strobe
alu_op  out  3  ALU operation select
alu_en  out  1  ALU execute strobe
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load; valid with dmem_req
pc_inc  out  1  PC+1 pulse
pc_load  out  1  PC load pulse
pc_target  out  PC_W  jump target = ir[PC_W-1:0]
halted  out  1  sticky halt indicator
illegal_op  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Opcode map (zero-extended compare):
  - 0 NOP
  - 1..7 ALU; alu_op = opcode[2:0]; dest <= f(A,B)
  - 8 LOAD; dest <= mem[A]
  - 9 STORE; mem[A] <= B
  - A JMP
  - B BZ; jump if zero_flag
  - F HALT
  - all others illegal
- States: FETCH, DECODE, EXEC, WB, HALT. All outputs registered.
- Reset: state=FETCH, ir=0, every output 0 (including halted). Any in-flight ack in the reset cycle is ignored.
- FETCH:
  - instr_req=1 held until instr_ack. Ack may arrive in the first req cycle.
  - On ack: ir <= instr_rdata; go to DECODE; instr_req drops next cycle.
- DECODE (1 cycle):
  - addr_A, addr_B, addr_dest driven from ir; they hold until the next fetch completes.
  - en_decA=en_decB=1 for ALU, LOAD and STORE only.
  - Go to EXEC.
- EXEC:
  - ALU: alu_en=1 for 1 cycle -> WB.
  - LOAD: dmem_req=1, dmem_we=0 until dmem_ack -> WB.
  - STORE: dmem_req=1, dmem_we=1 until dmem_ack; pc_inc pulse -> FETCH.
  - JMP: pc_load=1 for 1 cycle -> FETCH.
  - BZ: if zero_flag (sampled this cycle) pc_load pulse, else pc_inc pulse -> FETCH.
  - NOP: pc_inc pulse -> FETCH.
  - Illegal: illegal_op pulse + pc_inc pulse -> FETCH; treated as NOP.
  - HALT: -> HALT state.
- WB: en_dest=1, rf_we=1, pc_inc=1 for exactly 1 cycle -> FETCH.
- HALT: halted=1; all strobes 0; remains until reset.
- Invariants:
  - Exactly one of pc_inc / pc_load per retired non-HALT instruction; never both.
  - Never assert instr_req and dmem_req together.
- Latency with same-cycle acks: ALU/LOAD 4 cycles; NOP/JMP/BZ/STORE 3 cycles.
- Ack inputs outside their request window are ignored.

Decomposition:
- Package cu_pkg: state enum (FETCH, DECODE, EXEC, WB, HALT); opcode localparams (OP_NOP, OP_LOAD=8, OP_STORE=9, OP_JMP=A, OP_BZ=B, OP_HALT=F); field-slicing localparams derived from the parameters.
- One natural sub-module, cu_decode: combinational ir -> fields, instruction class, illegal flag.

Test Plan:
- ALU: ir=0x1234, same-cycle acks -> DECODE addr_A=2, addr_B=3, addr_dest=4; EXEC alu_op=1, alu_en=1; WB rf_we=1, pc_inc=1; next instr_req 4 cycles after first.
- LOAD with wait: ir=0x8506, dmem_ack after 3 cycles -> dmem_req high 3 cycles, dmem_we=0; then rf_we=1 with addr_dest=6.
- STORE: ir=0x9120 -> dmem_req=1, dmem_we=1 until ack; pc_inc pulse; no rf_we.
- Branch: ir=0xB0FF with zero_flag=1 -> pc_load=1, pc_target=0x0FF, no pc_inc; zero_flag=0 -> pc_inc only. JMP ir=0xA123 -> pc_target=0x123.
- Illegal/HALT: ir=0xC000 -> illegal_op 1-cycle pulse, pc_inc, refetch. ir=0xF000 -> halted=1 stays high 20 cycles, no req.
- Reset mid-op: reset during LOAD dmem_req wait -> next cycle all outputs 0, state FETCH; first post-reset cycle instr_req=1, halted=0.
